// File: rtl/account_store.sv
// Per-card account database and session controller: stores balance, PIN, retry count
// and lock flag per card, and runs the insert / PIN-check / commit / eject session.
//
// Handshake: every input strobe (card_valid, psw_valid, op_done, card_eject) is a
// single-cycle pulse sampled on the rising edge; there is no back-pressure. The
// response is registered on that same edge. Strobes with no meaning in the current
// state are dropped.
module account_store #(
    parameter int CARD_W       = 3,
    parameter int PSW_W        = 4,
    parameter int BAL_W        = 20,
    parameter int USERS_NUM    = 7,
    parameter int MAX_TRIES    = 3,
    parameter int INIT_BALANCE = 1000,
    parameter int PSW_BASE     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_valid,
    input  logic [CARD_W-1:0] card_number,
    input  logic              psw_valid,
    input  logic [PSW_W-1:0]  password_input,
    input  logic              op_done,
    input  logic [BAL_W-1:0]  updated_balance,
    input  logic              card_eject,
    output logic [BAL_W-1:0]  balance,
    output logic              auth_ok,
    output logic              wrong_psw,
    output logic              locked,
    output logic              invalid_card,
    output logic              busy
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PSW = 2'd1,
        AUTH     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CARD_W-1:0]   card_q, card_d;
    logic [BAL_W-1:0]    bal_q   [USERS_NUM];
    logic [BAL_W-1:0]    bal_d   [USERS_NUM];
    logic [PSW_W-1:0]    psw_q   [USERS_NUM];
    logic [PSW_W-1:0]    psw_d   [USERS_NUM];
    logic [TRY_W-1:0]    tries_q [USERS_NUM];
    logic [TRY_W-1:0]    tries_d [USERS_NUM];
    logic                lock_q  [USERS_NUM];
    logic                lock_d  [USERS_NUM];

    logic [BAL_W-1:0]    balance_q, balance_d;
    logic                auth_ok_q, auth_ok_d;
    logic                wrong_psw_q, wrong_psw_d;
    logic                locked_q, locked_d;
    logic                invalid_card_q, invalid_card_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d        = state_q;
        card_d         = card_q;
        bal_d          = bal_q;
        psw_d          = psw_q;
        tries_d        = tries_q;
        lock_d         = lock_q;
        balance_d      = balance_q;
        auth_ok_d      = auth_ok_q;
        wrong_psw_d    = 1'b0;
        locked_d       = 1'b0;
        invalid_card_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_valid) begin
                    if (int'(card_number) >= USERS_NUM) begin
                        invalid_card_d = 1'b1;
                    end else if (lock_q[card_number]) begin
                        locked_d = 1'b1;
                    end else begin
                        card_d  = card_number;
                        state_d = WAIT_PSW;
                    end
                end
            end
            WAIT_PSW: begin
                // Eject has priority: a PIN arriving with it is dropped untouched.
                if (card_eject) begin
                    state_d   = IDLE;
                    balance_d = '0;
                    auth_ok_d = 1'b0;
                end else if (psw_valid) begin
                    if (password_input == psw_q[card_q]) begin
                        tries_d[card_q] = '0;
                        balance_d       = bal_q[card_q];
                        auth_ok_d       = 1'b1;
                        state_d         = AUTH;
                    end else if (int'(tries_q[card_q]) + 1 >= MAX_TRIES) begin
                        wrong_psw_d     = 1'b1;
                        locked_d        = 1'b1;
                        lock_d[card_q]  = 1'b1;
                        tries_d[card_q] = '0;
                        state_d         = IDLE;
                    end else begin
                        wrong_psw_d     = 1'b1;
                        tries_d[card_q] = tries_q[card_q] + TRY_W'(1);
                    end
                end
            end
            AUTH: begin
                // Commit is applied before a same-cycle eject so the new balance persists.
                if (op_done) begin
                    bal_d[card_q] = updated_balance;
                    balance_d     = updated_balance;
                end
                if (card_eject) begin
                    state_d   = IDLE;
                    balance_d = '0;
                    auth_ok_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                balance_d = '0;
                auth_ok_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            card_q         <= '0;
            balance_q      <= '0;
            auth_ok_q      <= 1'b0;
            wrong_psw_q    <= 1'b0;
            locked_q       <= 1'b0;
            invalid_card_q <= 1'b0;
            busy_q         <= 1'b0;
            for (int i = 0; i < USERS_NUM; i++) begin
                bal_q[i]   <= BAL_W'(INIT_BALANCE);
                psw_q[i]   <= PSW_W'(PSW_BASE + i);
                tries_q[i] <= '0;
                lock_q[i]  <= 1'b0;
            end
        end else begin
            state_q        <= state_d;
            card_q         <= card_d;
            balance_q      <= balance_d;
            auth_ok_q      <= auth_ok_d;
            wrong_psw_q    <= wrong_psw_d;
            locked_q       <= locked_d;
            invalid_card_q <= invalid_card_d;
            busy_q         <= busy_d;
            bal_q          <= bal_d;
            psw_q          <= psw_d;
            tries_q        <= tries_d;
            lock_q         <= lock_d;
        end
    end

    assign balance      = balance_q;
    assign auth_ok      = auth_ok_q;
    assign wrong_psw    = wrong_psw_q;
    assign locked       = locked_q;
    assign invalid_card = invalid_card_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_account_store.sv
// Bench for account_store: directed session scenarios followed by random traffic,
// checked cycle by cycle against a behavioural account model through an expected queue.
module tb_account_store;

  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic         card_valid;
  logic [2:0]   card_number;
  logic         psw_valid;
  logic [3:0]   password_input;
  logic         op_done;
  logic [19:0]  updated_balance;
  logic         card_eject;
  logic [19:0]  balance;
  logic         auth_ok;
  logic         wrong_psw;
  logic         locked;
  logic         invalid_card;
  logic         busy;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int           n_tests = 0;
  int           n_fail  = 0;

  // behavioural model state
  int           m_state;
  int           m_card;
  logic [19:0]  m_bal[7];
  int           m_tries[7];
  bit           m_lock[7];
  logic [19:0]  m_balance;
  bit           m_auth, m_wrong, m_lk, m_inv;

  account_store dut (
    .clk(clk), .rst(rst),
    .card_valid(card_valid), .card_number(card_number),
    .psw_valid(psw_valid), .password_input(password_input),
    .op_done(op_done), .updated_balance(updated_balance),
    .card_eject(card_eject),
    .balance(balance), .auth_ok(auth_ok), .wrong_psw(wrong_psw),
    .locked(locked), .invalid_card(invalid_card), .busy(busy)
  );

  assign obs = {balance, auth_ok, wrong_psw, locked, invalid_card, busy};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got bal=%0d auth=%b wrong=%b lock=%b inv=%b busy=%b, exp bal=%0d auth=%b wrong=%b lock=%b inv=%b busy=%b",
               tag, got[24:5], got[4], got[3], got[2], got[1], got[0],
               exp[24:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    return {m_balance, m_auth, m_wrong, m_lk, m_inv, (m_state != 0)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_card = 0; m_balance = '0; m_auth = 0;
    m_wrong = 0; m_lk = 0; m_inv = 0;
    for (int i = 0; i < 7; i++) begin
      m_bal[i] = 20'd1000; m_tries[i] = 0; m_lock[i] = 0;
    end
  endtask

  task automatic model_step(input bit cv, input int cn, input bit pv, input int pin,
                            input bit od, input int ub, input bit ce);
    m_wrong = 0; m_lk = 0; m_inv = 0;
    if (m_state == 0) begin
      if (cv) begin
        if (cn > 6) m_inv = 1;
        else if (m_lock[cn]) m_lk = 1;
        else begin m_card = cn; m_state = 1; end
      end
    end else if (m_state == 1) begin
      if (ce) begin
        m_state = 0; m_balance = '0; m_auth = 0;
      end else if (pv) begin
        if (pin == (1 + m_card) % 16) begin
          m_tries[m_card] = 0; m_balance = m_bal[m_card]; m_auth = 1; m_state = 2;
        end else begin
          m_wrong = 1;
          m_tries[m_card]++;
          if (m_tries[m_card] == 3) begin
            m_lk = 1; m_lock[m_card] = 1; m_tries[m_card] = 0; m_state = 0;
          end
        end
      end
    end else begin
      if (od) begin
        m_bal[m_card] = 20'(ub); m_balance = 20'(ub);
      end
      if (ce) begin
        m_state = 0; m_balance = '0; m_auth = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, predict, then compare once the edge has registered them.
  task automatic step(input string tag, input bit cv, input int cn, input bit pv, input int pin,
                      input bit od, input int ub, input bit ce);
    @(negedge clk);
    card_valid      = cv;
    card_number     = cn[2:0];
    psw_valid       = pv;
    password_input  = pin[3:0];
    op_done         = od;
    updated_balance = ub[19:0];
    card_eject      = ce;
    model_step(cv, cn, pv, pin, od, ub, ce);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic insert(input string tag, input int cn);
    step(tag, 1, cn, 0, 0, 0, 0, 0);
  endtask

  task automatic pin(input string tag, input int p);
    step(tag, 0, 0, 1, p, 0, 0, 0);
  endtask

  task automatic eject(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_out());
    check_eq(tag, obs, exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    card_valid = 0; card_number = '0; psw_valid = 0; password_input = '0;
    op_done = 0; updated_balance = '0; card_eject = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(model_out());
    check_eq("reset", obs, exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    idle("idle_after_reset");

    // 1: basic authentication
    insert("t1_insert", 2);
    pin("t1_pin", 3);
    // 2: commit and persistence across sessions
    step("t2_commit", 0, 0, 0, 0, 1, 750, 0);
    eject("t2_eject");
    insert("t2_reinsert", 2);
    pin("t2_pin", 3);
    eject("t2_eject2");
    // ops outside IDLE-only events are ignored in IDLE
    step("idle_ignore", 0, 0, 1, 3, 1, 5, 1);
    // 3: lockout after three wrong PINs
    insert("t3_insert", 4);
    pin("t3_wrong1", 0);
    idle("t3_gap");
    pin("t3_wrong2", 0);
    pin("t3_wrong3_lock", 0);
    insert("t3_locked_reinsert", 4);
    // 4: invalid card, then card 0
    insert("t4_invalid", 7);
    insert("t4_card0", 0);
    step("t4_reinsert_ignored", 1, 5, 0, 0, 0, 0, 0);
    pin("t4_pin", 1);
    eject("t4_eject");
    // tries survive eject; PIN with eject is dropped
    insert("tr_insert", 5);
    pin("tr_wrong1", 9);
    step("tr_pin_eject", 0, 0, 1, 9, 0, 0, 1);
    insert("tr_reinsert", 5);
    pin("tr_wrong2", 9);
    pin("tr_good", 6);
    eject("tr_eject");
    // 5: commit and eject in the same cycle
    insert("t5_insert", 1);
    pin("t5_pin", 2);
    step("t5_commit_eject", 0, 0, 0, 0, 1, 42, 1);
    insert("t5_reinsert", 1);
    pin("t5_pin2", 2);
    eject("t5_eject");
    // 6: reset mid-session restores everything
    insert("t6_insert", 3);
    pin("t6_pin", 4);
    step("t6_commit", 0, 0, 0, 0, 1, 500, 0);
    async_reset("t6_async_reset");
    insert("t6_reinsert", 3);
    pin("t6_pin2", 4);
    eject("t6_eject");
    insert("t6_card4_unlocked", 4);
    eject("t6_eject4");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int cn, p;
      cn = $urandom_range(0, 7);
      p  = ($urandom_range(0, 1) == 1) ? (1 + m_card) % 16 : $urandom_range(0, 15);
      step("rand",
           $urandom_range(0, 3) == 0, cn,
           $urandom_range(0, 2) == 0, p,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1048575),
           $urandom_range(0, 7) == 0);
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
